mix_mode_ctrl: RTL
==================

Name: mix_mode_ctrl

Overview:
Mode sequencer for the camera mix datapath. It accepts effect-change requests from two debounced keys and a host register port, and holds them as a pending mode. It commits the pending mode to gamma_ctrl/saturation_ctrl only on a frame boundary (rising edge of vs_i). It then asserts a mask for a configurable number of frames, so downstream logic can blank the transient output while the median/sobel line buffers refill.

Parameters:
SETTLE_FRAMES, 4'd2, number of vs_i rising edges mask_o stays high after a frame-boundary commit (0 = no mask).
TIMEOUT_CYC, 24'd2_000_000, pixel_clk cycles in PENDING with no vs_i edge before a forced commit.
GAMMA_INIT, 2'd0, reset value of gamma_ctrl (0 raw, 1 square, 2 sqrt).
EFFECT_INIT, 2'd0, reset value of saturation_ctrl (0 raw, 1 saturation, 2 grey, 3 sobel).

Ports:
pixel_clk  input  1  pixel clock, all logic on rising edge
rst_n  input  1  synchronous reset, active low
vs_i  input  1  frame sync from the sensor side, active high
key_gamma_p  input  1  one-cycle pulse: step pending gamma 0→1→2→0
key_effect_p  input  1  one-cycle pulse: step pending effect 0→1→2→3→0
host_wr  input  1  one-cycle write strobe from host
host_gamma  input  2  host gamma value (3 stored as 0)
host_effect  input  2  host effect value
host_ack  output  1  one-cycle pulse, the cycle after host_wr
gamma_ctrl  output  2  committed gamma select
saturation_ctrl  output  2  committed effect select
mask_o  output  1  high while output is settling after a commit
busy_o  output  1  high in PENDING or SETTLE
timeout_o  output  1  one-cycle pulse on a forced commit

Behaviour:
- Reset (rst_n=0 at a clock edge): gamma_ctrl=GAMMA_INIT, saturation_ctrl=EFFECT_INIT, pending regs equal the same values. mask_o, busy_o, host_ack, timeout_o, vs_1d, frame counter and cycle counter all 0. State IDLE. Reset mid-SETTLE or mid-PENDING discards any pending change.
- Edge detect: vs_1d registers vs_i; vs_rise = vs_i & ~vs_1d.
- Request arbitration, evaluated each cycle on the pending regs (pg, pe):
  - host_wr has priority. pg=(host_gamma==3)?0:host_gamma, pe=host_effect. Keys in the same cycle are dropped.
  - Otherwise key_gamma_p steps pg and key_effect_p steps pe. Both keys in the same cycle apply both steps.
  - Steps are relative to the current pending value, not the committed value.
  - Requests are accepted in every state.
- diff = (pg,pe) != (gamma_ctrl,saturation_ctrl), computed from the registered pending values.
- IDLE:
  - diff=1 → PENDING, cycle counter cleared.
  - Otherwise stay in IDLE.
- PENDING:
  - Cycle counter increments each cycle.
  - On vs_rise: commit (gamma_ctrl<=pg, saturation_ctrl<=pe). If SETTLE_FRAMES=0 go to IDLE; otherwise go to SETTLE with mask_o<=1 and frame counter<=0.
  - Else if counter==TIMEOUT_CYC-1: commit, timeout_o pulses 1 cycle, go to IDLE, no mask.
  - Else if diff=0 (the user stepped back to the committed mode): go to IDLE with no commit.
- SETTLE:
  - Each vs_rise increments the frame counter.
  - On the vs_rise where counter==SETTLE_FRAMES-1: mask_o<=0. Then go to IDLE, and onward to PENDING on the next cycle if diff.
  - Commits never occur in SETTLE.
- Outputs are registered. gamma_ctrl, saturation_ctrl and mask_o change on the clock edge following the cycle in which vs_rise is seen.
- busy_o = (state != IDLE), registered with the state.
- host_ack <= host_wr.
- A vs_rise in the same cycle as a request commits the old pending value. The new request is handled by the next PENDING pass.
- Counter widths: frame counter 4 bits, cycle counter 24 bits. Neither counter wraps: each is cleared on state entry.

Test Plan:
1. Reset, then one key_effect_p pulse, then vs_i rise 100 cycles later → saturation_ctrl 0→1 exactly 1 cycle after the rise. mask_o high for 2 frames, low 1 cycle after the 2nd subsequent rise. busy_o low afterwards.
2. host_wr with gamma=3, effect=3 in the same cycle as key_gamma_p → host_ack the next cycle. After a vs_i rise, gamma_ctrl=0 and saturation_ctrl=3; the key is ignored.
3. Four key_effect_p pulses before any vs_i rise → pending wraps back to 0, state returns to IDLE, no commit, mask_o never asserted.
4. TIMEOUT_CYC=100, one key_gamma_p, vs_i held low → gamma_ctrl=1 after 100 cycles, timeout_o single-cycle pulse, mask_o stays 0.
5. key_effect_p during SETTLE (effect 1→2) → no change until mask_o drops. The next vs_i rise then commits 2 and starts a new 2-frame mask.
6. rst_n low for one cycle in mid-SETTLE with a pending change → outputs return to INIT values, mask_o=0, busy_o=0; a later vs_i rise produces no commit.

Source files
------------

// File: rtl/mix_mode_ctrl.sv
// mix_mode_ctrl
// Mode sequencer for the camera mix datapath. Effect-change requests from two
// debounced keys and a host register port update a pending mode; the pending
// mode is committed to gamma_ctrl/saturation_ctrl only on a frame boundary
// (rising edge of vs_i), or forced after TIMEOUT_CYC cycles without one. After
// a frame-boundary commit, mask_o stays high for SETTLE_FRAMES frames so the
// downstream line buffers can refill before the output is shown.
//
// Ports:
//   pixel_clk        in   pixel clock, all logic on the rising edge
//   rst_n            in   synchronous reset, active low
//   vs_i             in   frame sync, active high
//   key_gamma_p      in   one-cycle pulse, step pending gamma 0->1->2->0
//   key_effect_p     in   one-cycle pulse, step pending effect 0->1->2->3->0
//   host_wr          in   one-cycle host write strobe (has priority over keys)
//   host_gamma[1:0]  in   host gamma value (3 is stored as 0)
//   host_effect[1:0] in   host effect value
//   host_ack         out  one-cycle pulse the cycle after host_wr
//   gamma_ctrl[1:0]  out  committed gamma select
//   saturation_ctrl[1:0] out committed effect select
//   mask_o           out  high while the output settles after a commit
//   busy_o           out  high in PENDING or SETTLE
//   timeout_o        out  one-cycle pulse on a forced commit
//
// Handshake: host_wr is a fire-and-forget strobe; the block always accepts it
// and answers with host_ack exactly one cycle later. There is no back-pressure.

module mix_mode_ctrl #(
  parameter logic [3:0]  SETTLE_FRAMES = 4'd2,
  parameter logic [23:0] TIMEOUT_CYC   = 24'd2_000_000,
  parameter logic [1:0]  GAMMA_INIT    = 2'd0,
  parameter logic [1:0]  EFFECT_INIT   = 2'd0
) (
  input  logic       pixel_clk,
  input  logic       rst_n,
  input  logic       vs_i,
  input  logic       key_gamma_p,
  input  logic       key_effect_p,
  input  logic       host_wr,
  input  logic [1:0] host_gamma,
  input  logic [1:0] host_effect,
  output logic       host_ack,
  output logic [1:0] gamma_ctrl,
  output logic [1:0] saturation_ctrl,
  output logic       mask_o,
  output logic       busy_o,
  output logic       timeout_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SETTLE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        vs_1d;
  logic        vs_rise;
  logic [1:0]  pg_q, pg_d;
  logic [1:0]  pe_q, pe_d;
  logic [23:0] cyc_q, cyc_d;
  logic [3:0]  frame_q, frame_d;
  logic        diff;
  logic        cyc_hit;
  logic        frame_hit;
  logic        commit;
  logic        mask_d;
  logic        timeout_d;

  assign vs_rise   = vs_i & ~vs_1d;
  // diff looks at the registered pending values, so a request seen this
  // cycle only influences the FSM from the next cycle on.
  assign diff      = (pg_q != gamma_ctrl) || (pe_q != saturation_ctrl);
  assign cyc_hit   = (cyc_q == TIMEOUT_CYC - 24'd1);
  assign frame_hit = (frame_q == SETTLE_FRAMES - 4'd1);

  // Request arbitration: host write wins and drops any key in the same cycle.
  // Key steps are relative to the pending value, never the committed one.
  always_comb begin
    pg_d = pg_q;
    pe_d = pe_q;
    if (host_wr) begin
      pg_d = (host_gamma == 2'd3) ? 2'd0 : host_gamma;
      pe_d = host_effect;
    end else begin
      if (key_gamma_p) pg_d = (pg_q >= 2'd2) ? 2'd0 : pg_q + 2'd1;
      if (key_effect_p) pe_d = pe_q + 2'd1;
    end
  end

  // State register
  always_ff @(posedge pixel_clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and counter logic. Counters are cleared on state entry, so
  // neither can wrap: PENDING ends at TIMEOUT_CYC-1, SETTLE at SETTLE_FRAMES-1.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    frame_d = frame_q;
    case (state_q)
      IDLE: begin
        if (diff) begin
          state_d = PENDING;
          cyc_d   = 24'd0;
        end
      end
      PENDING: begin
        cyc_d = cyc_q + 24'd1;
        if (vs_rise) begin
          if (SETTLE_FRAMES == 4'd0) begin
            state_d = IDLE;
          end else begin
            state_d = SETTLE;
            frame_d = 4'd0;
          end
        end else if (cyc_hit) begin
          state_d = IDLE;
        end else if (!diff) begin
          state_d = IDLE;
        end
      end
      SETTLE: begin
        if (vs_rise) begin
          frame_d = frame_q + 4'd1;
          if (frame_hit) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode. A frame-boundary commit takes priority over a timeout
  // that happens to expire in the same cycle.
  always_comb begin
    commit    = 1'b0;
    timeout_d = 1'b0;
    mask_d    = mask_o;
    case (state_q)
      PENDING: begin
        if (vs_rise) begin
          commit = 1'b1;
          if (SETTLE_FRAMES != 4'd0) mask_d = 1'b1;
        end else if (cyc_hit) begin
          commit    = 1'b1;
          timeout_d = 1'b1;
        end
      end
      SETTLE: begin
        if (vs_rise && frame_hit) mask_d = 1'b0;
      end
      default: begin
        commit = 1'b0;
      end
    endcase
  end

  // Registered datapath and outputs
  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      vs_1d           <= 1'b0;
      pg_q            <= GAMMA_INIT;
      pe_q            <= EFFECT_INIT;
      gamma_ctrl      <= GAMMA_INIT;
      saturation_ctrl <= EFFECT_INIT;
      cyc_q           <= 24'd0;
      frame_q         <= 4'd0;
      mask_o          <= 1'b0;
      busy_o          <= 1'b0;
      host_ack        <= 1'b0;
      timeout_o       <= 1'b0;
    end else begin
      vs_1d     <= vs_i;
      pg_q      <= pg_d;
      pe_q      <= pe_d;
      cyc_q     <= cyc_d;
      frame_q   <= frame_d;
      mask_o    <= mask_d;
      busy_o    <= (state_d != IDLE);
      host_ack  <= host_wr;
      timeout_o <= timeout_d;
      // Commit uses the registered pending value, so a request arriving in
      // the same cycle as vs_rise waits for the next PENDING pass.
      if (commit) begin
        gamma_ctrl      <= pg_q;
        saturation_ctrl <= pe_q;
      end
    end
  end

endmodule
